// File: rtl/gpr_wb_scheduler.sv
// GPR writeback scheduler: arbitrates EXU/LSU onto the single GPR write port and tracks busy registers.
// Optional WB_BYPASS_EN adds forwarding of the in-flight write to decode.
module gpr_wb_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int RF_SIZE    = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid_i,
    input  logic [RF_SIZE-1:0]      issue_rd_i,
    output logic                    issue_ready_o,
    input  logic [RF_SIZE-1:0]      rs1_i,
    input  logic [RF_SIZE-1:0]      rs2_i,
    output logic                    hazard_o,
    input  logic                    exu_valid_i,
    input  logic [RF_SIZE-1:0]      exu_rd_i,
    input  logic [DATA_WIDTH-1:0]   exu_data_i,
    output logic                    exu_ready_o,
    input  logic                    lsu_valid_i,
    input  logic [RF_SIZE-1:0]      lsu_rd_i,
    input  logic [DATA_WIDTH-1:0]   lsu_data_i,
    output logic                    lsu_ready_o,
`ifdef WB_BYPASS_EN
    output logic                    fwd_rs1_o,
    output logic                    fwd_rs2_o,
    output logic [DATA_WIDTH-1:0]   fwd_data_o,
`endif
    output logic                    gpr_we_o,
    output logic [RF_SIZE-1:0]      gpr_rd_o,
    output logic [DATA_WIDTH-1:0]   gpr_data_o,
    output logic [2**RF_SIZE-1:0]   busy_o
);

    localparam int NREG = 2**RF_SIZE;

    typedef enum logic {SRC_EXU, SRC_LSU} src_e;

    src_e                  last_q, last_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic [NREG-1:0]       set_vec, clr_vec;
    logic                  gpr_we_q, gpr_we_d;
    logic [RF_SIZE-1:0]    gpr_rd_q, gpr_rd_d;
    logic [DATA_WIDTH-1:0] gpr_data_q, gpr_data_d;
    logic                  exu_gnt, lsu_gnt, issue_acc;
    logic                  haz1, haz2;
    logic                  fwd1, fwd2;

    // Round-robin: on a conflict the source not granted last time wins.
    always_comb begin
        exu_gnt   = rst_n & exu_valid_i & (~lsu_valid_i | (last_q == SRC_LSU));
        lsu_gnt   = rst_n & lsu_valid_i & (~exu_valid_i | (last_q == SRC_EXU));
        issue_acc = rst_n & issue_valid_i & ~busy_q[issue_rd_i];
    end

    always_comb begin
        last_d     = last_q;
        gpr_we_d   = 1'b0;
        gpr_rd_d   = gpr_rd_q;
        gpr_data_d = gpr_data_q;
        unique case (1'b1)
            exu_gnt: begin
                last_d     = SRC_EXU;
                gpr_we_d   = (exu_rd_i != '0);
                gpr_rd_d   = exu_rd_i;
                gpr_data_d = exu_data_i;
            end
            lsu_gnt: begin
                last_d     = SRC_LSU;
                gpr_we_d   = (lsu_rd_i != '0);
                gpr_rd_d   = lsu_rd_i;
                gpr_data_d = lsu_data_i;
            end
            default: ;
        endcase
    end

    // Set beats clear when an issue lands on the edge that retires the same register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_acc && (issue_rd_i != '0)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        if (gpr_we_q) begin
            clr_vec[gpr_rd_q] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_comb begin
`ifdef WB_BYPASS_EN
        fwd1 = gpr_we_q & (gpr_rd_q == rs1_i) & (rs1_i != '0);
        fwd2 = gpr_we_q & (gpr_rd_q == rs2_i) & (rs2_i != '0);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        haz1 = (rs1_i != '0) & busy_q[rs1_i] & ~fwd1;
        haz2 = (rs2_i != '0) & busy_q[rs2_i] & ~fwd2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= SRC_LSU;
            busy_q     <= '0;
            gpr_we_q   <= 1'b0;
            gpr_rd_q   <= '0;
            gpr_data_q <= '0;
        end else begin
            last_q     <= last_d;
            busy_q     <= busy_d;
            gpr_we_q   <= gpr_we_d;
            gpr_rd_q   <= gpr_rd_d;
            gpr_data_q <= gpr_data_d;
        end
    end

    assign issue_ready_o = issue_acc;
    assign exu_ready_o   = exu_gnt;
    assign lsu_ready_o   = lsu_gnt;
    assign hazard_o      = haz1 | haz2;
    assign gpr_we_o      = gpr_we_q;
    assign gpr_rd_o      = gpr_rd_q;
    assign gpr_data_o    = gpr_data_q;
    assign busy_o        = busy_q;
`ifdef WB_BYPASS_EN
    assign fwd_rs1_o     = fwd1;
    assign fwd_rs2_o     = fwd2;
    assign fwd_data_o    = gpr_data_q;
`endif

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Bench for gpr_wb_scheduler: reference model plus a queue of expected GPR writes.
// Build with +define+WB_BYPASS_EN to exercise the forwarding outputs.
module tb_gpr_wb_scheduler;

    localparam int DW = 64;
    localparam int RW = 5;

    typedef struct packed {
        logic          we;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid_i;
    logic [RW-1:0] issue_rd_i;
    logic          issue_ready_o;
    logic [RW-1:0] rs1_i, rs2_i;
    logic          hazard_o;
    logic          exu_valid_i;
    logic [RW-1:0] exu_rd_i;
    logic [DW-1:0] exu_data_i;
    logic          exu_ready_o;
    logic          lsu_valid_i;
    logic [RW-1:0] lsu_rd_i;
    logic [DW-1:0] lsu_data_i;
    logic          lsu_ready_o;
    logic          gpr_we_o;
    logic [RW-1:0] gpr_rd_o;
    logic [DW-1:0] gpr_data_o;
    logic [31:0]   busy_o;
`ifdef WB_BYPASS_EN
    logic          fwd_rs1_o, fwd_rs2_o;
    logic [DW-1:0] fwd_data_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    wr_t           sb[$];
    logic [31:0]   m_busy;
    logic          m_last;
    logic          m_we;
    logic [RW-1:0] m_rd;
    logic [DW-1:0] m_data;

    always #5 clk = ~clk;

    gpr_wb_scheduler #(.DATA_WIDTH(DW), .RF_SIZE(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issue_valid_i),
        .issue_rd_i    (issue_rd_i),
        .issue_ready_o (issue_ready_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .hazard_o      (hazard_o),
        .exu_valid_i   (exu_valid_i),
        .exu_rd_i      (exu_rd_i),
        .exu_data_i    (exu_data_i),
        .exu_ready_o   (exu_ready_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_rd_i      (lsu_rd_i),
        .lsu_data_i    (lsu_data_i),
        .lsu_ready_o   (lsu_ready_o),
`ifdef WB_BYPASS_EN
        .fwd_rs1_o     (fwd_rs1_o),
        .fwd_rs2_o     (fwd_rs2_o),
        .fwd_data_o    (fwd_data_o),
`endif
        .gpr_we_o      (gpr_we_o),
        .gpr_rd_o      (gpr_rd_o),
        .gpr_data_o    (gpr_data_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0;
        m_last = 1'b1;
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        sb.delete();
        sb.push_back('0);
    endtask

    task automatic idle_inputs();
        issue_valid_i = 1'b0;
        issue_rd_i    = '0;
        rs1_i         = '0;
        rs2_i         = '0;
        exu_valid_i   = 1'b0;
        exu_rd_i      = '0;
        exu_data_i    = '0;
        lsu_valid_i   = 1'b0;
        lsu_rd_i      = '0;
        lsu_data_i    = '0;
    endtask

    // One clock: compare at the falling edge, advance the model, leave #1 past the rising edge.
    task automatic step();
        wr_t e;
        logic e_iss, e_exu, e_lsu, f1, f2, e_haz;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("gpr_we", {63'd0, gpr_we_o}, {63'd0, e.we});
            chk("gpr_rd", {59'd0, gpr_rd_o}, {59'd0, e.rd});
            chk("gpr_data", gpr_data_o, e.data);
        end
        chk("busy", {32'd0, busy_o}, {32'd0, m_busy});
        e_iss = issue_valid_i & ~m_busy[issue_rd_i];
        e_exu = exu_valid_i & (~lsu_valid_i | m_last);
        e_lsu = lsu_valid_i & (~exu_valid_i | ~m_last);
`ifdef WB_BYPASS_EN
        f1 = m_we & (m_rd == rs1_i) & (rs1_i != 0);
        f2 = m_we & (m_rd == rs2_i) & (rs2_i != 0);
        chk("fwd_rs1", {63'd0, fwd_rs1_o}, {63'd0, f1});
        chk("fwd_rs2", {63'd0, fwd_rs2_o}, {63'd0, f2});
`else
        f1 = 1'b0;
        f2 = 1'b0;
`endif
        e_haz = ((rs1_i != 0) & m_busy[rs1_i] & ~f1) | ((rs2_i != 0) & m_busy[rs2_i] & ~f2);
        chk("issue_ready", {63'd0, issue_ready_o}, {63'd0, e_iss});
        chk("exu_ready", {63'd0, exu_ready_o}, {63'd0, e_exu});
        chk("lsu_ready", {63'd0, lsu_ready_o}, {63'd0, e_lsu});
        chk("hazard", {63'd0, hazard_o}, {63'd0, e_haz});
        if (m_we) m_busy[m_rd] = 1'b0;
        if (e_iss && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
        if (e_exu) begin
            m_last = 1'b0;
            m_we   = (exu_rd_i != 0);
            m_rd   = exu_rd_i;
            m_data = exu_data_i;
        end else if (e_lsu) begin
            m_last = 1'b1;
            m_we   = (lsu_rd_i != 0);
            m_rd   = lsu_rd_i;
            m_data = lsu_data_i;
        end else begin
            m_we = 1'b0;
        end
        sb.push_back('{we: m_we, rd: m_rd, data: m_data});
        @(posedge clk);
        #1;
    endtask

    task automatic write_exu(input logic [RW-1:0] rd, input logic [DW-1:0] d);
        exu_valid_i = 1'b1;
        exu_rd_i    = rd;
        exu_data_i  = d;
        step();
        exu_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {32'd0, busy_o}, 64'd0);
        chk("rst_we", {63'd0, gpr_we_o}, 64'd0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 6; i++) begin
            rs1_i = RW'($urandom);
            rs2_i = RW'($urandom);
            step();
            chk("idle_hazard", {63'd0, hazard_o}, 64'd0);
        end
        rs1_i = '0;
        rs2_i = '0;

        // Conflict straight after reset: EXU first, LSU holds then wins.
        exu_valid_i = 1'b1; exu_rd_i = 5'd3; exu_data_i = 64'h11;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd4; lsu_data_i = 64'h22;
        #1;
        chk("conf_lsu_loses", {63'd0, lsu_ready_o}, 64'd0);
        step();
        chk("conf_rd3", {59'd0, gpr_rd_o}, 64'd3);
        chk("conf_d11", gpr_data_o, 64'h11);
        exu_valid_i = 1'b0;
        step();
        chk("conf_rd4", {59'd0, gpr_rd_o}, 64'd4);
        chk("conf_d22", gpr_data_o, 64'h22);
        lsu_valid_i = 1'b0;
        step();

        // RAW on x5 resolved by an EXU write.
        issue_valid_i = 1'b1; issue_rd_i = 5'd5;
        step();
        issue_valid_i = 1'b0;
        rs1_i = 5'd5;
        #1;
        chk("raw_hazard", {63'd0, hazard_o}, 64'd1);
        step();
        write_exu(5'd5, 64'hDEAD);
        chk("wb5_we", {63'd0, gpr_we_o}, 64'd1);
        chk("wb5_rd", {59'd0, gpr_rd_o}, 64'd5);
        chk("wb5_data", gpr_data_o, 64'hDEAD);
        step();
        chk("clr5_busy", {63'd0, busy_o[5]}, 64'd0);
        chk("clr5_hazard", {63'd0, hazard_o}, 64'd0);
        rs1_i = '0;

        // WAW stall, then set-wins on a clearing edge of a non-busy x7.
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        #1;
        chk("waw_stall", {63'd0, issue_ready_o}, 64'd0);
        step();
        issue_valid_i = 1'b0;
        write_exu(5'd7, 64'h70);
        step();
        chk("x7_free", {63'd0, busy_o[7]}, 64'd0);
        write_exu(5'd7, 64'h71);
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        step();
        issue_valid_i = 1'b0;
        chk("set_wins", {63'd0, busy_o[7]}, 64'd1);
        write_exu(5'd7, 64'h72);
        step();

        // LSU write to x0 is granted and dropped.
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_data_i = 64'h55;
        #1;
        chk("x0_ready", {63'd0, lsu_ready_o}, 64'd1);
        step();
        lsu_valid_i = 1'b0;
        chk("x0_we", {63'd0, gpr_we_o}, 64'd0);
        chk("x0_busy", {63'd0, busy_o[0]}, 64'd0);
        step();

`ifdef WB_BYPASS_EN
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        step();
        issue_valid_i = 1'b0;
        write_exu(5'd9, 64'h99);
        rs2_i = 5'd9;
        #1;
        chk("byp_fwd2", {63'd0, fwd_rs2_o}, 64'd1);
        chk("byp_hazard", {63'd0, hazard_o}, 64'd0);
        chk("byp_data", fwd_data_o, 64'h99);
        step();
        rs2_i = '0;
        step();
`endif

        // Asynchronous reset while a write is in flight.
        issue_valid_i = 1'b1; issue_rd_i = 5'd6;
        step();
        issue_valid_i = 1'b0;
        write_exu(5'd6, 64'h66);
        chk("pre_rst_we", {63'd0, gpr_we_o}, 64'd1);
        chk("pre_rst_busy", {63'd0, busy_o[6]}, 64'd1);
        exu_valid_i = 1'b1; issue_valid_i = 1'b1; issue_rd_i = 5'd10;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {32'd0, busy_o}, 64'd0);
        chk("arst_we", {63'd0, gpr_we_o}, 64'd0);
        chk("arst_rd", {59'd0, gpr_rd_o}, 64'd0);
        chk("arst_data", gpr_data_o, 64'd0);
        chk("arst_iss_rdy", {63'd0, issue_ready_o}, 64'd0);
        chk("arst_exu_rdy", {63'd0, exu_ready_o}, 64'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step();

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            issue_valid_i = 1'($urandom);
            issue_rd_i    = RW'($urandom);
            rs1_i         = RW'($urandom);
            rs2_i         = RW'($urandom);
            exu_valid_i   = 1'($urandom);
            exu_rd_i      = RW'($urandom);
            exu_data_i    = {$urandom, $urandom};
            lsu_valid_i   = 1'($urandom);
            lsu_rd_i      = RW'($urandom);
            lsu_data_i    = {$urandom, $urandom};
            step();
        end
        idle_inputs();
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
